// File: rtl/hazard_stall_ctrl.sv
// Pipeline stall/flush sequencer: memory wait > redirect > load-use, with memory timeout detect.
// Optional HAZARD_PERF_CNT_EN adds saturating stall-cycle and flush-event counters.
module hazard_stall_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_is_load,
    input  logic             ex_redirect,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             stall_pc,
    output logic             stall_if_id,
    output logic             stall_id_ex,
    output logic             stall_ex_mem,
    output logic             stall_mem_wb,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             mem_err,
`ifdef HAZARD_PERF_CNT_EN
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events,
`endif
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StMemWait = 2'd1,
        StErr     = 2'd2
    } state_e;

    state_e           r_state;
    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_mem_err;

    logic w_mwait;
    logic w_lu;
    logic w_stall_all;
    logic w_hold_front;
    logic w_flush_if;
    logic w_flush_id;

    assign w_mwait = mem_req & ~mem_ready;
    assign w_lu    = ex_is_load & (ex_rd != 5'd0) &
                     ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));

    // RUN and MEM_WAIT share one decode: a MEM_WAIT release cycle behaves as a RUN cycle.
    always_comb begin
        w_stall_all  = 1'b0;
        w_hold_front = 1'b0;
        w_flush_if   = 1'b0;
        w_flush_id   = 1'b0;
        if (!rst) begin
            unique case (r_state)
                StRun, StMemWait: begin
                    if (w_mwait) begin
                        w_stall_all = 1'b1;
                    end else if (ex_redirect) begin
                        w_flush_if = 1'b1;
                        w_flush_id = 1'b1;
                    end else if (w_lu) begin
                        w_hold_front = 1'b1;
                        w_flush_id   = 1'b1;
                    end
                end
                default: w_stall_all = 1'b1;
            endcase
        end
    end

    assign stall_pc     = w_stall_all | w_hold_front;
    assign stall_if_id  = w_stall_all | w_hold_front;
    assign stall_id_ex  = w_stall_all;
    assign stall_ex_mem = w_stall_all;
    assign stall_mem_wb = w_stall_all;
    assign flush_if_id  = w_flush_if;
    assign flush_id_ex  = w_flush_id;
    assign mem_err      = r_mem_err;
    assign state        = r_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= StRun;
            r_wait_cnt <= '0;
            r_mem_err  <= 1'b0;
        end else begin
            unique case (r_state)
                StRun: begin
                    if (w_mwait) begin
                        r_state    <= StMemWait;
                        r_wait_cnt <= CNT_W'(1);
                    end
                end
                StMemWait: begin
                    if (!w_mwait) begin
                        r_state    <= StRun;
                        r_wait_cnt <= '0;
                    end else if (r_wait_cnt == CNT_W'(MEM_TIMEOUT)) begin
                        r_state   <= StErr;
                        r_mem_err <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                StErr: r_state <= StErr;
                default: r_state <= StRun;
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cycles;
    logic [CNT_W-1:0] r_flush_events;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= '0;
            r_flush_events <= '0;
        end else begin
            if (stall_pc && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + 1'b1;
            end
            if (flush_if_id && (r_flush_events != '1)) begin
                r_flush_events <= r_flush_events + 1'b1;
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_events = r_flush_events;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed vector bench for hazard_stall_ctrl; instance b uses MEM_TIMEOUT=3 for the timeout path.
module tb_hazard_stall_ctrl;

    typedef struct packed {
        logic       rst;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       use1;
        logic       use2;
        logic [4:0] exrd;
        logic       load;
        logic       redir;
        logic       req;
        logic       ready;
    } in_t;

    typedef struct packed {
        in_t        i;
        logic [6:0] o;
        logic [1:0] s;
    } vec_t;

    // {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb, flush_if_id, flush_id_ex}
    localparam logic [6:0] ONone = 7'b0000000;
    localparam logic [6:0] OLu   = 7'b1100001;
    localparam logic [6:0] OBr   = 7'b0000011;
    localparam logic [6:0] OAll  = 7'b1111100;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_use_rs1, id_use_rs2, ex_is_load, ex_redirect, mem_req, mem_ready;

    logic [6:0] outs_a, outs_b;
    logic [1:0] state_a, state_b;
    logic       err_a, err_b;
`ifdef HAZARD_PERF_CNT_EN
    logic [7:0] sc_a, fe_a, sc_b, fe_b;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hazard_stall_ctrl u_dut_a (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
        .ex_is_load(ex_is_load), .ex_redirect(ex_redirect), .mem_req(mem_req),
        .mem_ready(mem_ready), .stall_pc(outs_a[6]), .stall_if_id(outs_a[5]),
        .stall_id_ex(outs_a[4]), .stall_ex_mem(outs_a[3]), .stall_mem_wb(outs_a[2]),
        .flush_if_id(outs_a[1]), .flush_id_ex(outs_a[0]), .mem_err(err_a),
`ifdef HAZARD_PERF_CNT_EN
        .stall_cycles(sc_a), .flush_events(fe_a),
`endif
        .state(state_a)
    );

    hazard_stall_ctrl #(.MEM_TIMEOUT(3)) u_dut_b (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
        .ex_is_load(ex_is_load), .ex_redirect(ex_redirect), .mem_req(mem_req),
        .mem_ready(mem_ready), .stall_pc(outs_b[6]), .stall_if_id(outs_b[5]),
        .stall_id_ex(outs_b[4]), .stall_ex_mem(outs_b[3]), .stall_mem_wb(outs_b[2]),
        .flush_if_id(outs_b[1]), .flush_id_ex(outs_b[0]), .mem_err(err_b),
`ifdef HAZARD_PERF_CNT_EN
        .stall_cycles(sc_b), .flush_events(fe_b),
`endif
        .state(state_b)
    );

    function automatic in_t mk(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                               input logic u2, input logic [4:0] rd, input logic ld,
                               input logic rdir, input logic req, input logic rdy);
        in_t v;
        v.rst = 1'b0; v.rs1 = rs1; v.rs2 = rs2; v.use1 = u1; v.use2 = u2;
        v.exrd = rd; v.load = ld; v.redir = rdir; v.req = req; v.ready = rdy;
        return v;
    endfunction

    task automatic drive(input in_t v);
        rst = v.rst; id_rs1 = v.rs1; id_rs2 = v.rs2; id_use_rs1 = v.use1; id_use_rs2 = v.use2;
        ex_rd = v.exrd; ex_is_load = v.load; ex_redirect = v.redir;
        mem_req = v.req; mem_ready = v.ready;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One cycle: drive at negedge, check combinational outputs, then state after the edge.
    task automatic cyc(input string nm, input bit use_b, input in_t v, input logic [6:0] eo,
                       input logic [1:0] es);
        @(negedge clk);
        drive(v);
        #1;
        chk({nm, ".outs"}, use_b ? 32'(outs_b) : 32'(outs_a), 32'(eo));
        @(posedge clk);
        #1;
        chk({nm, ".state"}, use_b ? 32'(state_b) : 32'(state_a), 32'(es));
    endtask

    vec_t vecs[12];
    in_t  idle, lu, mw, rs;

    initial begin
        idle = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        lu   = mk(5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        mw   = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        rs   = idle;
        rs.rst = 1'b1;

        vecs[0]  = '{i: idle, o: ONone, s: 2'd0};
        vecs[1]  = '{i: lu, o: OLu, s: 2'd0};
        vecs[2]  = '{i: mk(5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0), o: ONone, s: 2'd0};
        vecs[3]  = '{i: mk(5'd7, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0), o: OLu, s: 2'd0};
        vecs[4]  = '{i: mk(5'd7, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0), o: ONone, s: 2'd0};
        vecs[5]  = '{i: mk(5'd7, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0), o: ONone, s: 2'd0};
        vecs[6]  = '{i: mk(5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0), o: OBr, s: 2'd0};
        vecs[7]  = '{i: mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0), o: OAll, s: 2'd1};
        vecs[8]  = '{i: mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0), o: OAll, s: 2'd1};
        vecs[9]  = '{i: mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1), o: OBr, s: 2'd0};
        vecs[10] = '{i: mw, o: OAll, s: 2'd1};
        vecs[11] = '{i: lu, o: OLu, s: 2'd0};

        // Reset with hazard inputs active: outputs must still be quiet.
        drive(mw);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.outs", 32'(outs_a), 32'(ONone));
        chk("reset.state", 32'(state_a), 32'd0);
        chk("reset.mem_err", 32'(err_a), 32'd0);

        for (int k = 0; k < 12; k++) begin
            cyc($sformatf("vec%0d", k), 1'b0, vecs[k].i, vecs[k].o, vecs[k].s);
        end

        // Four-cycle memory wait then release.
        cyc("mw3.c1", 1'b0, mw, OAll, 2'd1);
        for (int k = 2; k <= 4; k++) cyc($sformatf("mw3.c%0d", k), 1'b0, mw, OAll, 2'd1);
        cyc("mw3.rel", 1'b0, mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1), ONone, 2'd0);
        chk("mw3.mem_err", 32'(err_a), 32'd0);

        // Reset in the middle of a wait.
        cyc("rstmid.w1", 1'b0, mw, OAll, 2'd1);
        rs.req = 1'b1;
        cyc("rstmid.rst", 1'b0, rs, ONone, 2'd0);
        cyc("rstmid.idle", 1'b0, idle, ONone, 2'd0);

        // Timeout on instance b (MEM_TIMEOUT=3): ERR after the fourth wait cycle.
        for (int k = 1; k <= 3; k++) cyc($sformatf("to.w%0d", k), 1'b1, mw, OAll, 2'd1);
        chk("to.no_err_yet", 32'(err_b), 32'd0);
        cyc("to.w4", 1'b1, mw, OAll, 2'd2);
        chk("to.mem_err", 32'(err_b), 32'd1);
        cyc("to.ready", 1'b1, mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1), OAll, 2'd2);
        cyc("to.redir", 1'b1, mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0), OAll, 2'd2);
        chk("to.sticky", 32'(err_b), 32'd1);
        rs.req = 1'b0;
        cyc("to.rst", 1'b1, rs, ONone, 2'd0);
        chk("to.rst_err", 32'(err_b), 32'd0);
        cyc("to.idle", 1'b1, idle, ONone, 2'd0);

`ifdef HAZARD_PERF_CNT_EN
        cyc("perf.rst", 1'b0, rs, ONone, 2'd0);
        chk("perf.clr_sc", 32'(sc_a), 32'd0);
        cyc("perf.lu", 1'b0, lu, OLu, 2'd0);
        cyc("perf.idle", 1'b0, idle, ONone, 2'd0);
        for (int k = 1; k <= 4; k++) cyc($sformatf("perf.w%0d", k), 1'b0, mw, OAll, 2'd1);
        cyc("perf.rel", 1'b0, idle, ONone, 2'd0);
        chk("perf.stall5", 32'(sc_a), 32'd5);
        chk("perf.flush0", 32'(fe_a), 32'd0);
        cyc("perf.br", 1'b0, vecs[6].i, OBr, 2'd0);
        chk("perf.flush1", 32'(fe_a), 32'd1);
        chk("perf.stall_keep", 32'(sc_a), 32'd5);
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            drive(mw);
        end
        @(posedge clk);
        #1;
        chk("perf.sat", 32'(sc_a), 32'd255);
        cyc("perf.rst2", 1'b0, rs, ONone, 2'd0);
        chk("perf.sat_clr", 32'(sc_a), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
